// File: rtl/pwm_hbridge_pkg.sv
// Shared drive-state encoding and gate mapping for the H-bridge PWM channel.
package pwm_hbridge_pkg;

   typedef enum logic [1:0] {
      COAST = 2'b00,
      CCW   = 2'b01,
      CW    = 2'b10,
      BRAKE = 2'b11
   } drive_t;

   // Per-FET gate pattern for a bridge drive state.
   function automatic logic [3:0] gate_map(input drive_t s);
      logic [3:0] g;
      case (s)
         COAST:   g = 4'b0000;
         CCW:     g = 4'b0110;
         CW:      g = 4'b1001;
         default: g = 4'b0101;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Deadtime insertion: every drive-state change is preceded by DEADTIME coast cycles.
module pwm_deadtime
   import pwm_hbridge_pkg::*;
#(
   parameter int unsigned DEADTIME = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  drive_t     i_qual,
   output logic [1:0] o_pwmout,
   output logic [3:0] o_pwmout4
);

   localparam int unsigned   DTW     = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
   localparam logic [DTW-1:0] DT_LOAD = DTW'(DEADTIME);

   drive_t         r_last;
   logic [DTW-1:0] r_dt;
   drive_t         w_out;

   // Requests arriving while the timer runs are not queued; the input is
   // simply compared again once the timer has expired.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= COAST;
         r_dt   <= '0;
      end else if (r_dt == '0) begin
         if (i_qual != r_last) begin
            r_last <= i_qual;
            r_dt   <= DT_LOAD;
         end
      end else begin
         r_dt <= r_dt - 1'b1;
      end
   end

   assign w_out     = (r_dt == '0) ? r_last : COAST;
   assign o_pwmout  = w_out;
   assign o_pwmout4 = gate_map(w_out);

endmodule

// File: rtl/pwm_hbridge.sv
// H-bridge PWM channel: period counter, double-buffered duty, current limit,
// drive qualification; deadtime handled by pwm_deadtime.
module pwm_hbridge
   import pwm_hbridge_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEADTIME = 8,
   parameter int unsigned CLIP_EN  = 0,
   parameter int unsigned PWM_MIN  = 3,
   parameter int unsigned PWM_MAX  = 2**WIDTH - 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwmcntce,
   input  logic             pwmldce,
   input  logic [WIDTH-1:0] wrtdata,
   input  logic             centermode,
   input  logic             invertpwm,
   input  logic             enablepwm,
   input  logic             run,
   input  logic             currentlimit,
   output logic [1:0]       pwmout,
   output logic [3:0]       pwmout4,
   output logic             cyclestart,
   output logic             limitflag
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(PWM_MIN);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(PWM_MAX);

   logic [WIDTH-1:0] r_cnt;
   logic             r_down;
   logic             r_center;
   logic [WIDTH-1:0] r_duty_hold;
   logic [WIDTH-1:0] r_duty_sync;
   logic             r_seo;
   logic             r_limit;

   logic [WIDTH-1:0] w_duty_in;
   logic             w_bnd;
   logic             w_p;
   drive_t           w_qual;

   always_comb begin
      w_duty_in = wrtdata;
      if (CLIP_EN != 0) begin
         if (wrtdata < MIN_V)      w_duty_in = MIN_V;
         else if (wrtdata > MAX_V) w_duty_in = MAX_V;
      end
   end

   // In center mode r_down records the direction of the step that produced
   // r_cnt, so reaching 0 on the way down marks the boundary.
   assign w_bnd = pwmcntce & (r_center ? (r_down & (r_cnt == '0)) : (r_cnt == CNT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_down      <= 1'b0;
         r_center    <= 1'b0;
         r_duty_hold <= '0;
         r_duty_sync <= '0;
      end else begin
         if (pwmldce) r_duty_hold <= w_duty_in;
         if (w_bnd) begin
            r_duty_sync <= r_duty_hold;
            r_center    <= centermode;
         end
         if (pwmcntce) begin
            if (w_bnd) begin
               // Staying in center mode skips the already-visited 0; any
               // other transition starts the new period at 0.
               r_cnt  <= (r_center & centermode) ? WIDTH'(1) : '0;
               r_down <= 1'b0;
            end else if (!r_center) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (!r_down) begin
               if (r_cnt == CNT_MAX) begin
                  r_cnt  <= r_cnt - 1'b1;
                  r_down <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seo   <= 1'b0;
         r_limit <= 1'b0;
      end else begin
         r_seo   <= (r_cnt < r_duty_sync) & ~r_limit & ~currentlimit;
         r_limit <= currentlimit | (r_limit & ~w_bnd);
      end
   end

   assign w_p = r_seo ^ invertpwm;

   always_comb begin
      w_qual = COAST;
      if (!run)           w_qual = BRAKE;
      else if (enablepwm) w_qual = w_p ? CCW : CW;
   end

   pwm_deadtime #(
      .DEADTIME (DEADTIME)
   ) u_deadtime (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_qual    (w_qual),
      .o_pwmout  (pwmout),
      .o_pwmout4 (pwmout4)
   );

   assign cyclestart = w_bnd;
   assign limitflag  = r_limit;

endmodule

// File: tb/tb_pwm_hbridge.sv
// Directed bench for pwm_hbridge: counter periods, duty buffering, current
// limit, deadtime sequencing, reset and duty clipping.
module tb_pwm_hbridge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pwmcntce, pwmldce, centermode, invertpwm, enablepwm, run, currentlimit;
   logic [7:0] wrtdata;
   logic [1:0] pwmout, c_pwmout;
   logic [3:0] pwmout4, c_pwmout4;
   logic       cyclestart, limitflag, c_cyclestart, c_limitflag;

   int checks   = 0;
   int failures = 0;
   int len, hi, n;
   logic lim_first, lim_end;

   always #5 clk = ~clk;

   pwm_hbridge #(.WIDTH(8), .DEADTIME(8)) dut (
      .clk(clk), .rst_n(rst_n), .pwmcntce(pwmcntce), .pwmldce(pwmldce),
      .wrtdata(wrtdata), .centermode(centermode), .invertpwm(invertpwm),
      .enablepwm(enablepwm), .run(run), .currentlimit(currentlimit),
      .pwmout(pwmout), .pwmout4(pwmout4), .cyclestart(cyclestart), .limitflag(limitflag)
   );

   pwm_hbridge #(.WIDTH(8), .DEADTIME(8), .CLIP_EN(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .pwmcntce(pwmcntce), .pwmldce(pwmldce),
      .wrtdata(wrtdata), .centermode(centermode), .invertpwm(invertpwm),
      .enablepwm(enablepwm), .run(run), .currentlimit(currentlimit),
      .pwmout(c_pwmout), .pwmout4(c_pwmout4), .cyclestart(c_cyclestart), .limitflag(c_limitflag)
   );

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs until the next cyclestart sample; hi counts samples with seo high.
   task automatic run_period(input int wr_at, input logic [7:0] wr_val, input int cl_at,
                             output int p_len, output int p_hi,
                             output logic p_lim_first, output logic p_lim_end);
      p_len = 0;
      p_hi  = 0;
      p_lim_first = 1'b0;
      do begin
         if (p_len == wr_at) begin
            wrtdata = wr_val;
            pwmldce = 1'b1;
         end
         if (p_len == cl_at) currentlimit = 1'b1;
         tick(1);
         pwmldce      = 1'b0;
         currentlimit = 1'b0;
         p_len++;
         if (dut.r_seo) p_hi++;
         if (p_len == 1) p_lim_first = limitflag;
      end while (!cyclestart && p_len < 600);
      p_lim_end = limitflag;
   endtask

   task automatic wait_cs(output int cnt);
      cnt = 0;
      while (!cyclestart && cnt < 600) begin
         tick(1);
         cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; pwmcntce = 1'b0; pwmldce = 1'b0; wrtdata = '0;
      centermode = 1'b0; invertpwm = 1'b0; enablepwm = 1'b1; run = 1'b1; currentlimit = 1'b0;
      tick(3);
      check("rst_pwmout",    pwmout, 2'b00);
      check("rst_pwmout4",   pwmout4, 4'b0000);
      check("rst_cyclestart", cyclestart, 1'b0);
      check("rst_limitflag", limitflag, 1'b0);
      check("rst_c_outputs", {c_pwmout, c_pwmout4, c_cyclestart, c_limitflag}, 8'h00);

      // duty 0 with enable -> CW requested; captured at first edge, 8 coast clks
      rst_n = 1'b1;
      tick(1);
      check("dt_first", pwmout4, 4'b0000);
      tick(7);
      check("dt_last_coast", pwmout4, 4'b0000);
      tick(1);
      check("dt_cw_state", pwmout, 2'b10);
      check("dt_cw_gates", pwmout4, 4'b1001);

      // Edge mode, duty 64
      wrtdata = 8'd64; pwmldce = 1'b1;
      tick(1);
      pwmldce = 1'b0; pwmcntce = 1'b1;
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("edge_first_len", len, 255);
      check("edge_first_hi", hi, 0);
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("edge64_len", len, 256);
      check("edge64_hi", hi, 64);
      check("edge64_sync", dut.r_duty_sync, 64);

      // Mid-period write of 200 only affects the following period
      run_period(100, 8'd200, -1, len, hi, lim_first, lim_end);
      check("midwr_len", len, 256);
      check("midwr_hi", hi, 64);
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("edge200_hi", hi, 200);

      // Center mode; write of 100 coincides with the boundary, so 200 is used once more.
      // Counts 0..255..1 visited, 0 once per 510-tick period: 200 + 199 with duty 200.
      centermode = 1'b1; wrtdata = 8'd100; pwmldce = 1'b1;
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("ctr_first_len", len, 511);
      check("ctr_first_hi", hi, 399);
      check("ctr_same_clk_sync", dut.r_duty_sync, 200);
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("ctr_len", len, 510);
      check("ctr_sync100", dut.r_duty_sync, 100);
      // duty 100: count 0 once plus 1..99 on both slopes
      check("ctr100_hi_a", hi, 199);
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("ctr100_len", len, 510);
      check("ctr100_hi_b", hi, 199);

      // Back to edge mode, duty 128, then a 1-clk current limit pulse at count 10
      centermode = 1'b0; wrtdata = 8'd128; pwmldce = 1'b1;
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("back_edge_len", len, 256);
      check("back_edge_hi", hi, 101);
      run_period(-1, 8'd0, 11, len, hi, lim_first, lim_end);
      check("ilim_len", len, 256);
      check("ilim_hi", hi, 10);
      check("ilim_flag_held", lim_end, 1'b1);
      run_period(-1, 8'd0, -1, len, hi, lim_first, lim_end);
      check("ilim_clear_first", lim_first, 1'b0);
      check("ilim_next_hi", hi, 128);
      check("ilim_next_flag", lim_end, 1'b0);

      // Counter frozen at 255 with duty 128 -> seo low -> CW
      pwmcntce = 1'b0;
      tick(10);
      check("cw_settled", pwmout4, 4'b1001);
      run = 1'b0;
      tick(1);
      check("brake_dt_start", pwmout4, 4'b0000);
      tick(7);
      check("brake_dt_end", pwmout4, 4'b0000);
      tick(1);
      check("brake_state", pwmout, 2'b11);
      check("brake_gates", pwmout4, 4'b0101);

      // Request during deadtime is not queued
      run = 1'b1;
      tick(1);
      check("cw_dt_start", pwmout, 2'b00);
      tick(2);
      run = 1'b0;
      tick(6);
      check("no_queue_cw", pwmout4, 4'b1001);
      tick(1);
      check("brake_recapture", pwmout, 2'b00);

      // Inverted modulator output -> CCW
      run = 1'b1; invertpwm = 1'b1;
      tick(18);
      check("ccw_state", pwmout, 2'b01);
      check("ccw_gates", pwmout4, 4'b0110);

      // Asynchronous reset mid-deadtime with limit latched
      invertpwm = 1'b0;
      tick(1);
      currentlimit = 1'b1;
      tick(1);
      currentlimit = 1'b0;
      check("pre_rst_limit", limitflag, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_limit", limitflag, 1'b0);
      check("async_rst_pwm", {pwmout, pwmout4}, 6'd0);
      tick(2);
      rst_n = 1'b1;

      // Clipping instance: 0 -> 3, 255 -> 251
      wrtdata = 8'd0; pwmldce = 1'b1;
      tick(1);
      pwmldce = 1'b0;
      check("clip_hold_min", dut_c.r_duty_hold, 3);
      check("noclip_hold0", dut.r_duty_hold, 0);
      pwmcntce = 1'b1;
      wait_cs(n);
      check("rst_period_len", n, 255);
      wrtdata = 8'd255; pwmldce = 1'b1;
      tick(1);
      pwmldce = 1'b0;
      check("clip_sync_min", dut_c.r_duty_sync, 3);
      wait_cs(n);
      tick(1);
      check("clip_sync_max", dut_c.r_duty_sync, 251);
      check("noclip_sync255", dut.r_duty_sync, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
